// File: rtl/if_stage.sv
// Instruction-fetch stage with IF/ID pipeline register and a one-entry skid
// buffer. Issues word reads over a req/ack handshake and applies ID's jump
// redirect with a single delay-slot instruction always delivered.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branchEnable_i,
  input  logic [31:0] branchAddr_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o
);

  typedef enum logic {
    S_FETCH = 1'b0,
    S_WAIT  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        armed;            // low only until the first clock after reset release
  logic [31:0] fetch_pc;
  logic [31:0] target_q;
  logic        redirect_pending;
  logic [31:0] skid_pc;
  logic [31:0] skid_inst;

  logic        ack;
  logic        branch_take;
  logic [31:0] branch_tgt;
  logic [31:0] seq_pc;

  // An ack only counts while a request is actually outstanding.
  assign ack         = imem_ack_i & imem_req_o;
  // The jump leaves ID this cycle only if ID holds it and is not stalled.
  assign branch_take = branchEnable_i & valid_o & ~stall_i;
  assign branch_tgt  = {branchAddr_i[31:2], 2'b00};
  // Next sequential fetch address, honouring a redirect latched while waiting.
  assign seq_pc      = redirect_pending ? target_q : fetch_pc + 32'd4;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_FETCH;
    else      state <= state_next;
  end

  // Next-state logic: park in WAIT when a fetch lands behind a stalled ID.
  always_comb begin
    state_next = state;
    if (state == S_FETCH) begin
      if (ack && valid_o && stall_i) state_next = S_WAIT;
    end else begin
      if (!stall_i) state_next = S_FETCH;
    end
  end

  // Outputs: request whenever fetching, address is the current fetch PC.
  always_comb begin
    imem_req_o  = (state == S_FETCH) && armed;
    imem_addr_o = fetch_pc;
  end

  // Keep the request low while reset is held and for the release cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) armed <= 1'b0;
    else      armed <= 1'b1;
  end

  // Fetch PC advance and deferred redirect bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc         <= RESET_PC;
      target_q         <= 32'd0;
      redirect_pending <= 1'b0;
    end else if (state == S_FETCH) begin
      if (ack) begin
        // This ack is the delay slot when a jump is taken now.
        fetch_pc         <= branch_take ? branch_tgt : seq_pc;
        redirect_pending <= 1'b0;
      end else if (branch_take) begin
        // Delay slot still in flight: leave its address alone, redirect after.
        target_q         <= branch_tgt;
        redirect_pending <= 1'b1;
      end
    end else begin
      // In WAIT the skid already holds the delay slot.
      if (branch_take) fetch_pc <= branch_tgt;
    end
  end

  // IF/ID register and skid buffer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o      <= 32'd0;
      inst_o    <= NOP_INST;
      valid_o   <= 1'b0;
      skid_pc   <= 32'd0;
      skid_inst <= NOP_INST;
    end else if (state == S_FETCH) begin
      if (ack) begin
        if (!valid_o || !stall_i) begin
          pc_o    <= fetch_pc;
          inst_o  <= imem_rdata_i;
          valid_o <= 1'b1;
        end else begin
          skid_pc   <= fetch_pc;
          skid_inst <= imem_rdata_i;
        end
      end else if (!stall_i) begin
        valid_o <= 1'b0;
        inst_o  <= NOP_INST;
      end
    end else begin
      if (!stall_i) begin
        pc_o    <= skid_pc;
        inst_o  <= skid_inst;
        valid_o <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: memory with configurable wait states,
// a program-order model of the delivered instruction stream, and scenario tasks.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branchEnable_i = 1'b0;
  logic [31:0] branchAddr_i = 32'd0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;

  if_stage #(.RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branchEnable_i(branchEnable_i), .branchAddr_i(branchAddr_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_ack_i(imem_ack_i), .imem_rdata_i(imem_rdata_i),
    .pc_o(pc_o), .inst_o(inst_o), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc;
  int wait_fixed;
  logic [31:0] slow_addr;
  int slow_waits;
  logic spurious;
  logic mem_busy;
  int mem_cnt;
  int hold_viol, nop_viol, addr_viol;

  logic [31:0] got_pc[$];
  logic [31:0] got_inst[$];
  logic [31:0] got_tgt[$];
  logic        got_jmp[$];
  int          got_cyc[$];
  logic [31:0] ack_addr[$];
  int          ack_cyc[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  // Program order: sequential, except the instruction after a delay slot is the jump target.
  function automatic logic [31:0] model_pc(input int k);
    logic [31:0] e;
    e = RESET_PC;
    for (int i = 0; i < k; i++) begin
      if (i >= 1 && got_jmp[i-1]) e = got_tgt[i-1];
      else                        e = e + 32'd4;
    end
    return e;
  endfunction

  task automatic clear_logs();
    got_pc.delete(); got_inst.delete(); got_tgt.delete(); got_jmp.delete(); got_cyc.delete();
    ack_addr.delete(); ack_cyc.delete();
    hold_viol = 0; nop_viol = 0; addr_viol = 0; cyc = 0;
  endtask

  task automatic apply_reset();
    rst = 1'b0; mem_busy = 1'b0; mem_cnt = 0;
    stall_i = 1'b0; branchEnable_i = 1'b0; imem_ack_i = 1'b0;
    spurious = 1'b0; slow_addr = 32'h1; slow_waits = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    clear_logs();
  endtask

  // One clock: drive inputs, act as memory, log consumed beats and handshake events.
  task automatic cycle(input logic s, input logic be, input logic [31:0] ba);
    logic ack, pv, preq;
    logic [31:0] ppc, pinst, paddr;
    cyc++;
    stall_i = s; branchEnable_i = be; branchAddr_i = ba;
    if (imem_req_o && !mem_busy) begin
      mem_busy = 1'b1;
      if (imem_addr_o == slow_addr) mem_cnt = slow_waits;
      else if (wait_fixed < 0)      mem_cnt = $urandom_range(0, 2);
      else                          mem_cnt = wait_fixed;
    end
    ack = imem_req_o && mem_busy && (mem_cnt == 0);
    if (imem_req_o) imem_ack_i = ack;
    else            imem_ack_i = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
    imem_rdata_i = ack ? mem_word(imem_addr_o) : $urandom;
    if (ack) begin ack_addr.push_back(imem_addr_o); ack_cyc.push_back(cyc); end
    pv = valid_o; ppc = pc_o; pinst = inst_o; preq = imem_req_o; paddr = imem_addr_o;
    if (pv && !s) begin
      got_pc.push_back(ppc); got_inst.push_back(pinst); got_cyc.push_back(cyc);
      got_jmp.push_back(be); got_tgt.push_back({ba[31:2], 2'b00});
    end
    if (!pv && pinst !== NOP) nop_viol++;
    @(posedge clk); #1;
    if (ack) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (pv && s && (valid_o !== 1'b1 || pc_o !== ppc || inst_o !== pinst)) hold_viol++;
    if (preq && !ack && imem_req_o && imem_addr_o !== paddr) addr_viol++;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL reset_req got %b need 0", imem_req_o); end
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b need 0", valid_o); end
    n_cmp++; if (pc_o !== 32'd0) begin n_bad++; $display("FAIL reset_pc got %h need 0", pc_o); end
    n_cmp++; if (inst_o !== NOP) begin n_bad++; $display("FAIL reset_inst got %h need %h", inst_o, NOP); end
    $display("test_reset done");
  endtask

  task automatic test_zero_wait();
    apply_reset(); wait_fixed = 0;
    repeat (8) cycle(1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (ack_addr.size() < 3) begin n_bad++; $display("FAIL t1_acks got %0d need >=3", ack_addr.size()); end
    else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (ack_addr[i] !== RESET_PC + 32'(4 * i) || ack_cyc[i] !== ack_cyc[0] + i) begin
          n_bad++; $display("FAIL t1_addr[%0d] got %h@%0d need %h@%0d", i, ack_addr[i], ack_cyc[i], RESET_PC + 32'(4 * i), ack_cyc[0] + i);
        end
      end
      n_cmp++;
      if (got_pc.size() == 0 || got_pc[0] !== RESET_PC || got_cyc[0] !== ack_cyc[0] + 1) begin
        n_bad++; $display("FAIL t1_first_valid got %0d beats need pc %h one cycle after ack", got_pc.size(), RESET_PC);
      end
    end
    for (int k = 0; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_pc[k] !== model_pc(k) || got_inst[k] !== mem_word(model_pc(k))) begin
        n_bad++; $display("FAIL t1_stream[%0d] got %h/%h need %h/%h", k, got_pc[k], got_inst[k], model_pc(k), mem_word(model_pc(k))); break;
      end
    end
    $display("test_zero_wait: %0d beats", got_pc.size());
  endtask

  task automatic test_two_wait();
    apply_reset(); wait_fixed = 2;
    repeat (20) cycle(1'b0, 1'b0, 32'd0);
    n_cmp++; if (got_pc.size() < 5) begin n_bad++; $display("FAIL t2_beats got %0d need >=5", got_pc.size()); end
    for (int k = 1; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_cyc[k] - got_cyc[k-1] !== 3) begin
        n_bad++; $display("FAIL t2_spacing[%0d] got %0d need 3", k, got_cyc[k] - got_cyc[k-1]); break;
      end
    end
    n_cmp++; if (nop_viol !== 0) begin n_bad++; $display("FAIL t2_bubble_nop got %0d need 0", nop_viol); end
    n_cmp++; if (addr_viol !== 0) begin n_bad++; $display("FAIL t2_addr_stable got %0d need 0", addr_viol); end
    for (int k = 0; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_pc[k] !== model_pc(k) || got_inst[k] !== mem_word(model_pc(k))) begin
        n_bad++; $display("FAIL t2_stream[%0d] got %h/%h need %h/%h", k, got_pc[k], got_inst[k], model_pc(k), mem_word(model_pc(k))); break;
      end
    end
    $display("test_two_wait: %0d beats", got_pc.size());
  endtask

  task automatic test_stall_skid();
    apply_reset(); wait_fixed = 0;
    for (int i = 0; i < 10 && valid_o !== 1'b1; i++) cycle(1'b0, 1'b0, 32'd0);
    n_cmp++; if (valid_o !== 1'b1) begin n_bad++; $display("FAIL t3_fill got valid %b need 1", valid_o); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, 32'd0);
      n_cmp++; if (imem_req_o !== 1'b0) begin n_bad++; $display("FAIL t3_req_in_wait[%0d] got %b need 0", i, imem_req_o); end
    end
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    n_cmp++; if (hold_viol !== 0) begin n_bad++; $display("FAIL t3_hold got %0d need 0", hold_viol); end
    n_cmp++; if (got_pc.size() < 6) begin n_bad++; $display("FAIL t3_beats got %0d need >=6", got_pc.size()); end
    for (int k = 0; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_pc[k] !== model_pc(k) || got_inst[k] !== mem_word(model_pc(k))) begin
        n_bad++; $display("FAIL t3_stream[%0d] got %h/%h need %h/%h", k, got_pc[k], got_inst[k], model_pc(k), mem_word(model_pc(k))); break;
      end
    end
    $display("test_stall_skid: %0d beats", got_pc.size());
  endtask

  // Jump from reset code to 0x100, then 0x100 jumps to 0x400; slow=1 delays the 0x104 ack.
  task automatic test_jump(input logic slow);
    int j;
    apply_reset(); wait_fixed = 0;
    if (slow) begin slow_addr = 32'h104; slow_waits = 2; end
    for (int i = 0; i < 40 && got_pc.size() < 7; i++)
      cycle(1'b0, valid_o && (pc_o == RESET_PC || pc_o == 32'h100), (pc_o == RESET_PC) ? 32'h100 : 32'h400);
    n_cmp++;
    if (got_pc.size() < 5) begin n_bad++; $display("FAIL jump%0d_beats got %0d need >=5", slow, got_pc.size()); end
    else begin
      n_cmp++; if (got_pc[2] !== 32'h100) begin n_bad++; $display("FAIL jump%0d_pc2 got %h need 00000100", slow, got_pc[2]); end
      n_cmp++; if (got_pc[3] !== 32'h104) begin n_bad++; $display("FAIL jump%0d_pc3 got %h need 00000104", slow, got_pc[3]); end
      n_cmp++; if (got_pc[4] !== 32'h400) begin n_bad++; $display("FAIL jump%0d_pc4 got %h need 00000400", slow, got_pc[4]); end
      if (slow) begin
        n_cmp++;
        if (got_cyc[3] - got_cyc[2] !== 3) begin n_bad++; $display("FAIL jump1_delay got %0d need 3", got_cyc[3] - got_cyc[2]); end
      end
    end
    j = -1;
    for (int i = 0; i < ack_addr.size(); i++) if (ack_addr[i] == 32'h104 && j < 0) j = i;
    n_cmp++;
    if (j < 0 || j + 1 >= ack_addr.size() || ack_addr[j+1] !== 32'h400) begin
      n_bad++; $display("FAIL jump%0d_fetch_after_slot got idx %0d need 00000400 after 00000104", slow, j);
    end
    n_cmp++; if (addr_viol !== 0) begin n_bad++; $display("FAIL jump%0d_addr_stable got %0d need 0", slow, addr_viol); end
    for (int k = 0; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_pc[k] !== model_pc(k) || got_inst[k] !== mem_word(model_pc(k))) begin
        n_bad++; $display("FAIL jump%0d_stream[%0d] got %h/%h need %h/%h", slow, k, got_pc[k], got_inst[k], model_pc(k), mem_word(model_pc(k))); break;
      end
    end
    $display("test_jump slow=%0d: %0d beats", slow, got_pc.size());
  endtask

  task automatic test_wrap();
    apply_reset(); wait_fixed = 0;
    for (int i = 0; i < 20 && got_pc.size() < 6; i++)
      cycle(1'b0, valid_o && pc_o == RESET_PC, 32'hFFFF_FFF9);
    n_cmp++;
    if (got_pc.size() < 5) begin n_bad++; $display("FAIL wrap_beats got %0d need >=5", got_pc.size()); end
    else begin
      n_cmp++; if (got_pc[2] !== 32'hFFFF_FFF8) begin n_bad++; $display("FAIL wrap_align got %h need fffffff8", got_pc[2]); end
      n_cmp++; if (got_pc[3] !== 32'hFFFF_FFFC) begin n_bad++; $display("FAIL wrap_last got %h need fffffffc", got_pc[3]); end
      n_cmp++; if (got_pc[4] !== 32'h0) begin n_bad++; $display("FAIL wrap_zero got %h need 00000000", got_pc[4]); end
    end
    $display("test_wrap: %0d beats", got_pc.size());
  endtask

  task automatic test_async_reset();
    apply_reset(); wait_fixed = 2;
    repeat (5) cycle(1'b0, 1'b0, 32'd0);
    n_cmp++; if (imem_req_o !== 1'b1) begin n_bad++; $display("FAIL t6_pre_req got %b need 1", imem_req_o); end
    #1 rst = 1'b0; mem_busy = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin n_bad++; $display("FAIL t6_req_rst req %b valid %b need 0 0", imem_req_o, valid_o); end
    n_cmp++; if (pc_o !== 32'd0 || inst_o !== NOP) begin n_bad++; $display("FAIL t6_req_rst_data pc %h inst %h need 0 0", pc_o, inst_o); end
    @(posedge clk); #1 rst = 1'b1; clear_logs(); wait_fixed = 0;
    for (int i = 0; i < 10 && valid_o !== 1'b1; i++) cycle(1'b0, 1'b0, 32'd0);
    cycle(1'b1, 1'b0, 32'd0);
    n_cmp++; if (imem_req_o !== 1'b0 || valid_o !== 1'b1) begin n_bad++; $display("FAIL t6_pre_wait req %b valid %b need 0 1", imem_req_o, valid_o); end
    #1 rst = 1'b0; mem_busy = 1'b0;
    #1;
    n_cmp++; if (imem_req_o !== 1'b0 || valid_o !== 1'b0) begin n_bad++; $display("FAIL t6_wait_rst req %b valid %b need 0 0", imem_req_o, valid_o); end
    n_cmp++; if (pc_o !== 32'd0 || inst_o !== NOP) begin n_bad++; $display("FAIL t6_wait_rst_data pc %h inst %h need 0 0", pc_o, inst_o); end
    @(posedge clk); #1 rst = 1'b1; stall_i = 1'b0; clear_logs();
    repeat (6) cycle(1'b0, 1'b0, 32'd0);
    n_cmp++;
    if (ack_addr.size() == 0 || ack_addr[0] !== RESET_PC) begin n_bad++; $display("FAIL t6_refetch got %0d acks need first %h", ack_addr.size(), RESET_PC); end
    for (int k = 0; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_pc[k] !== model_pc(k) || got_inst[k] !== mem_word(model_pc(k))) begin
        n_bad++; $display("FAIL t6_stream[%0d] got %h/%h need %h/%h", k, got_pc[k], got_inst[k], model_pc(k), mem_word(model_pc(k))); break;
      end
    end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    logic s, be, armed;
    logic [31:0] ba;
    apply_reset(); wait_fixed = -1; spurious = 1'b1;
    for (int i = 0; i < 400; i++) begin
      s = ($urandom_range(0, 9) < 3);
      armed = (got_jmp.size() > 0) && got_jmp[got_jmp.size()-1];
      be = !armed && ($urandom_range(0, 9) < 2);
      ba = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(s, be, ba);
    end
    n_cmp++; if (got_pc.size() < 50) begin n_bad++; $display("FAIL rnd_progress got %0d need >=50", got_pc.size()); end
    n_cmp++; if (hold_viol !== 0) begin n_bad++; $display("FAIL rnd_hold got %0d need 0", hold_viol); end
    n_cmp++; if (nop_viol !== 0) begin n_bad++; $display("FAIL rnd_bubble_nop got %0d need 0", nop_viol); end
    n_cmp++; if (addr_viol !== 0) begin n_bad++; $display("FAIL rnd_addr_stable got %0d need 0", addr_viol); end
    for (int k = 0; k < got_pc.size(); k++) begin
      n_cmp++;
      if (got_pc[k] !== model_pc(k) || got_inst[k] !== mem_word(model_pc(k))) begin
        n_bad++; $display("FAIL rnd_stream[%0d] got %h/%h need %h/%h", k, got_pc[k], got_inst[k], model_pc(k), mem_word(model_pc(k))); break;
      end
    end
    $display("test_random: %0d beats", got_pc.size());
  endtask

  initial begin
    wait_fixed = 0; spurious = 1'b0; slow_addr = 32'h1; slow_waits = 0;
    mem_busy = 1'b0; mem_cnt = 0;
    clear_logs();
    test_reset();
    test_zero_wait();
    test_two_wait();
    test_stall_skid();
    test_jump(1'b0);
    test_jump(1'b1);
    test_wrap();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired need completion");
    $fatal(1);
  end

endmodule
